candidate_collector: RTL and testbench
======================================

// Module: candidate_collector
// PURPOSE
//  Downstream of the I2LBS window classifier. Captures each accepted face window
//  (candidate=1 with inspect_done=1) at its resized-frame coordinate.
//  Scales that coordinate back to original-camera coordinates and buffers results in a FIFO.
//  Streams results to the reporting/overlay logic over a valid/ready interface.
// PARAMETERS
//  DATA_WIDTH_12                12  coordinate width
//  FIFO_DEPTH                   16  result entries, power of 2
//  FRAME_ORIGINAL_CAMERA_WIDTH  10  original frame width  (px)
//  FRAME_ORIGINAL_CAMERA_HEIGHT 10  original frame height (px)
//  FRAME_RESIZE_CAMERA_WIDTH    10  resized frame width   (px)
//  FRAME_RESIZE_CAMERA_HEIGHT   10  resized frame height  (px)
//  MERGE_DIST                   2   neighbourhood radius (px), used only with CANDIDATE_MERGE_EN
// PORTS
//  clk_fpga        in   1   system clock, all logic on rising edge
//  reset_fpga_n    in   1   asynchronous active-low reset
//  i_frame_start   in   1   1-cycle pulse at start of each resized frame
//  i_inspect_done  in   1   classifier finished the current window
//  i_candidate     in   1   window verdict; sampled only when i_inspect_done=1
//  i_resize_x      in   12  resized x of the window under inspection
//  i_resize_y      in   12  resized y of the window under inspection
//  o_valid         out  1   o_ori_x/o_ori_y hold a result
//  i_ready         in   1   consumer accepts the result
//  o_ori_x         out  12  original-frame x
//  o_ori_y         out  12  original-frame y
//  o_count         out  12  candidates accepted this frame, saturating
//  o_overflow      out  1   sticky flag: a candidate was dropped this frame
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, pipeline invalid, merge history invalid.
//  Event: hit = i_inspect_done & i_candidate, sampled each clock.
//    i_candidate is ignored when i_inspect_done=0.
//  Scaling:
//    localparams SCALE_X = (ORIG_W<<8)/RESIZE_W and SCALE_Y = (ORIG_H<<8)/RESIZE_H.
//    ori = (resize*SCALE) >> 8, computed at 24-bit intermediate width.
//    Result truncated to 12 bits, then clamped to ORIG-1.
//  Pipeline, 2 stages:
//    S1 registers the coordinates and the 24-bit products on hit.
//    S2 shifts and clamps, then writes the FIFO.
//    Push occurs at edge N+2 for a hit at edge N.
//    o_valid rises at earliest edge N+3 (FIFO head is registered).
//    Back-to-back hits on consecutive cycles are all accepted.
//  Handshake:
//    Pop happens when o_valid & i_ready.
//    o_ori_x/o_ori_y stay stable while o_valid=1 and i_ready=0.
//    o_valid never drops without a pop.
//  FIFO full:
//    Push with no simultaneous pop: entry dropped, o_overflow<=1, o_count unchanged.
//    Push with simultaneous pop: accepted, occupancy unchanged.
//  Empty: o_valid=0; i_ready is ignored.
//  o_count increments once per FIFO write and saturates at 12'hFFF.
//  i_frame_start:
//    Clears o_count, o_overflow and merge history on the next edge.
//    Does not flush the FIFO or the pipeline.
//    If a push lands in the same cycle, o_count becomes 1.
//  Reset asserted mid-operation: immediate clear; in-flight and buffered results are lost.
// CONFIGURATION
//  CANDIDATE_MERGE_EN defined:
//    S2 compares the new result with the last written result of this frame.
//    If |dx|<=MERGE_DIST and |dy|<=MERGE_DIST, the result is discarded.
//    A discarded result changes neither o_count nor o_overflow.
//    The first result after i_frame_start is always written.
//  CANDIDATE_MERGE_EN undefined: every hit is pushed; no history registers exist.
// STRUCTURE
//  Shared package face_detect_pkg:
//    DATA_WIDTH_12, SCALE_FRAC=8.
//    typedef struct packed {logic[11:0] x; logic[11:0] y;} coord_t.
//  Sub-module candidate_fifo:
//    Synchronous FIFO of coord_t with registered head.
//    Ports push/pop/full/empty; depth FIFO_DEPTH.
//  Top level holds the event qualify logic, the scale pipeline, the counters and the merge filter.
// TESTING (ORIG 20x20, RESIZE 10x10, so SCALE=512; FIFO_DEPTH 4)
//  1. Hit at (3,4), i_ready=1 -> o_valid at edge +3 with (6,8); o_count=1.
//  2. i_candidate=1 with i_inspect_done=0 -> no push; o_valid stays 0.
//  3. Hits at (9,9) on cycles 0..5 with i_ready=0 -> 4 entries (18,18) buffered.
//     o_overflow=1; o_count=4; holding i_ready high then drains exactly 4.
//  4. FIFO full, pop and push in the same cycle -> push accepted, o_overflow stays 0.
//  5. i_frame_start during stall -> o_count=0 and o_overflow=0; FIFO contents preserved.
//  6. CANDIDATE_MERGE_EN: hits (3,3),(4,4),(8,8) -> outputs (6,6),(16,16); o_count=2.

Source files
------------

// File: rtl/face_detect_pkg.sv
// Shared types and helpers for the face-detect result path.
// Coordinates are 12 bits wide. The x/y scale factors are fixed point
// with SCALE_FRAC fraction bits, and products are formed at 24 bits.
package face_detect_pkg;

   localparam int DATA_WIDTH_12 = 12;
   localparam int SCALE_FRAC    = 8;
   localparam int PROD_WIDTH    = 24;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
   } coord_t;

   // Drop the fraction bits and keep 12 integer bits (truncating).
   // The result is then limited to the last pixel of the original frame.
   function automatic logic [11:0] scale_clamp(input logic [23:0] prod,
                                               input logic [11:0] max_v);
      logic [3:0]  hi_unused;
      logic [11:0] trunc;
      logic [7:0]  frac_unused;
      {hi_unused, trunc, frac_unused} = prod;
      if (trunc > max_v) begin
         scale_clamp = max_v;
      end else begin
         scale_clamp = trunc;
      end
   endfunction

   // Absolute difference of two unsigned coordinates.
   function automatic logic [11:0] abs_diff(input logic [11:0] a,
                                            input logic [11:0] b);
      if (a >= b) begin
         abs_diff = a - b;
      end else begin
         abs_diff = b - a;
      end
   endfunction

endpackage

// File: rtl/candidate_fifo.sv
// Synchronous FIFO of coord_t entries. The head entry is registered.
// The head register always mirrors the oldest entry that was stored before
// the current edge. A newly written entry therefore becomes visible one
// edge after it is written. A push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module candidate_fifo
   import face_detect_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  logic [23:0] i_data,
   input  logic        i_pop,
   output logic        o_full,
   output logic        o_empty,
   output logic        o_valid,
   output logic [23:0] o_head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   coord_t        mem_q [DEPTH];
   coord_t        mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   coord_t        head_q, head_d;
   logic          head_valid_q, head_valid_d;
   logic          pop_ok_s;
   logic          push_ok_s;
   logic [CW-1:0] avail_s;

   assign o_full    = (cnt_q == DEPTH_C);
   assign o_empty   = (cnt_q == {CW{1'b0}});
   assign pop_ok_s  = i_pop & head_valid_q;
   assign push_ok_s = i_push & (~o_full | pop_ok_s);
   assign avail_s   = cnt_q - CW'(pop_ok_s);
   assign o_valid   = head_valid_q;
   assign o_head    = head_q;

   // Next-state for storage, pointers, occupancy and the head register.
   always_comb begin
      mem_d = mem_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = coord_t'(i_data);
      end else begin
         mem_d = mem_q;
      end
      wr_ptr_d     = wr_ptr_q + AW'(push_ok_s);
      rd_ptr_d     = rd_ptr_q + AW'(pop_ok_s);
      cnt_d        = cnt_q + CW'(push_ok_s) - CW'(pop_ok_s);
      head_d       = mem_q[rd_ptr_d];
      head_valid_d = (avail_s != {CW{1'b0}});
   end

   // FIFO state registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= {AW{1'b0}};
         rd_ptr_q     <= {AW{1'b0}};
         cnt_q        <= {CW{1'b0}};
         head_q       <= '0;
         head_valid_q <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         head_q       <= head_d;
         head_valid_q <= head_valid_d;
      end
   end

endmodule

// File: rtl/candidate_collector.sv
// Captures accepted face windows and scales them to original-camera
// coordinates through a two-stage pipeline. The results are buffered in
// candidate_fifo and streamed out over valid/ready.
// Optional feature macro: CANDIDATE_MERGE_EN. When it is defined, a
// result within MERGE_DIST of the last written result of the frame is
// discarded.
module candidate_collector
   import face_detect_pkg::*;
#(
   parameter int FIFO_DEPTH                   = 16,
   parameter int FRAME_ORIGINAL_CAMERA_WIDTH  = 10,
   parameter int FRAME_ORIGINAL_CAMERA_HEIGHT = 10,
   parameter int FRAME_RESIZE_CAMERA_WIDTH    = 10,
   parameter int FRAME_RESIZE_CAMERA_HEIGHT   = 10,
   parameter int MERGE_DIST                   = 2
) (
   input  logic        clk_fpga,
   input  logic        reset_fpga_n,
   input  logic        i_frame_start,
   input  logic        i_inspect_done,
   input  logic        i_candidate,
   input  logic [11:0] i_resize_x,
   input  logic [11:0] i_resize_y,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [11:0] o_ori_x,
   output logic [11:0] o_ori_y,
   output logic [11:0] o_count,
   output logic        o_overflow
);

   localparam int SCALE_X = (FRAME_ORIGINAL_CAMERA_WIDTH  << SCALE_FRAC) / FRAME_RESIZE_CAMERA_WIDTH;
   localparam int SCALE_Y = (FRAME_ORIGINAL_CAMERA_HEIGHT << SCALE_FRAC) / FRAME_RESIZE_CAMERA_HEIGHT;
   localparam logic [PROD_WIDTH-1:0] SCALE_X_C = PROD_WIDTH'(SCALE_X);
   localparam logic [PROD_WIDTH-1:0] SCALE_Y_C = PROD_WIDTH'(SCALE_Y);
   localparam logic [11:0] MAX_X_C     = 12'(FRAME_ORIGINAL_CAMERA_WIDTH - 1);
   localparam logic [11:0] MAX_Y_C     = 12'(FRAME_ORIGINAL_CAMERA_HEIGHT - 1);
   localparam logic [11:0] COUNT_MAX_C = 12'hFFF;

   logic                  hit_s;
   logic                  s1_valid_q, s1_valid_d;
   logic [PROD_WIDTH-1:0] s1_prod_x_q, s1_prod_x_d;
   logic [PROD_WIDTH-1:0] s1_prod_y_q, s1_prod_y_d;
   logic                  s2_valid_q, s2_valid_d;
   coord_t                s2_coord_q, s2_coord_d;
   logic                  push_s;
   logic                  pop_s;
   logic                  accept_s;
   logic                  drop_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic                  fifo_valid_s;
   logic [23:0]           fifo_head_s;
   coord_t                head_c;
   logic [11:0]           count_q, count_d;
   logic                  overflow_q, overflow_d;

   assign hit_s = i_inspect_done & i_candidate;

   // Stage 1 captures the scaled products of a hit (the products carry the coordinates).
   always_comb begin
      s1_valid_d = hit_s;
      if (hit_s) begin
         s1_prod_x_d = PROD_WIDTH'(i_resize_x) * SCALE_X_C;
         s1_prod_y_d = PROD_WIDTH'(i_resize_y) * SCALE_Y_C;
      end else begin
         s1_prod_x_d = s1_prod_x_q;
         s1_prod_y_d = s1_prod_y_q;
      end
   end

   // Stage 2 removes the fraction and clamps to the original frame.
   always_comb begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
         s2_coord_d.x = scale_clamp(s1_prod_x_q, MAX_X_C);
         s2_coord_d.y = scale_clamp(s1_prod_y_q, MAX_Y_C);
      end else begin
         s2_coord_d = s2_coord_q;
      end
   end

   // Pipeline registers; a reset drops anything in flight.
   always_ff @(posedge clk_fpga or negedge reset_fpga_n) begin
      if (!reset_fpga_n) begin
         s1_valid_q  <= 1'b0;
         s1_prod_x_q <= {PROD_WIDTH{1'b0}};
         s1_prod_y_q <= {PROD_WIDTH{1'b0}};
         s2_valid_q  <= 1'b0;
         s2_coord_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_prod_x_q <= s1_prod_x_d;
         s1_prod_y_q <= s1_prod_y_d;
         s2_valid_q  <= s2_valid_d;
         s2_coord_q  <= s2_coord_d;
      end
   end

`ifdef CANDIDATE_MERGE_EN
   localparam logic [11:0] MERGE_DIST_C = 12'(MERGE_DIST);

   logic   hist_valid_q, hist_valid_d;
   coord_t hist_q, hist_d;
   logic   near_s;
   logic   discard_s;

   // A frame start in the same cycle means the history is already stale, so
   // the result is kept.
   assign near_s    = (abs_diff(s2_coord_q.x, hist_q.x) <= MERGE_DIST_C) &&
                      (abs_diff(s2_coord_q.y, hist_q.y) <= MERGE_DIST_C);
   assign discard_s = s2_valid_q & hist_valid_q & near_s & ~i_frame_start;
   assign push_s    = s2_valid_q & ~discard_s;

   // The history tracks the last result that was actually written this frame.
   always_comb begin
      if (accept_s) begin
         hist_valid_d = 1'b1;
         hist_d       = s2_coord_q;
      end else if (i_frame_start) begin
         hist_valid_d = 1'b0;
         hist_d       = hist_q;
      end else begin
         hist_valid_d = hist_valid_q;
         hist_d       = hist_q;
      end
   end

   // Merge history registers.
   always_ff @(posedge clk_fpga or negedge reset_fpga_n) begin
      if (!reset_fpga_n) begin
         hist_valid_q <= 1'b0;
         hist_q       <= '0;
      end else begin
         hist_valid_q <= hist_valid_d;
         hist_q       <= hist_d;
      end
   end
`else
   localparam int MERGE_DIST_UNUSED = MERGE_DIST;

   assign push_s = s2_valid_q;
`endif

   // i_ready is only honoured while a registered head is on the outputs.
   assign pop_s    = fifo_valid_s & ~fifo_empty_s & i_ready;
   assign accept_s = push_s & (~fifo_full_s | pop_s);
   assign drop_s   = push_s & fifo_full_s & ~pop_s;

   candidate_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_fpga),
      .rst_n   (reset_fpga_n),
      .i_push  (push_s),
      .i_data  (s2_coord_q),
      .i_pop   (pop_s),
      .o_full  (fifo_full_s),
      .o_empty (fifo_empty_s),
      .o_valid (fifo_valid_s),
      .o_head  (fifo_head_s)
   );

   // Per-frame write counter (saturating) and sticky drop flag.
   always_comb begin
      if (i_frame_start) begin
         count_d    = accept_s ? 12'd1 : 12'd0;
         overflow_d = drop_s;
      end else begin
         if (accept_s && (count_q != COUNT_MAX_C)) begin
            count_d = count_q + 12'd1;
         end else begin
            count_d = count_q;
         end
         overflow_d = overflow_q | drop_s;
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk_fpga or negedge reset_fpga_n) begin
      if (!reset_fpga_n) begin
         count_q    <= 12'd0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign head_c     = coord_t'(fifo_head_s);
   assign o_valid    = fifo_valid_s;
   assign o_ori_x    = head_c.x;
   assign o_ori_y    = head_c.y;
   assign o_count    = count_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_candidate_collector.sv
// Scoreboard bench for candidate_collector (ORIG 20x20, RESIZE 10x10, FIFO depth 4).
// The stimulus queues the hand-computed expected results. A monitor pops
// the queue and compares whenever the DUT hands a result over.
// With CANDIDATE_MERGE_EN defined, the merge scenario replaces the
// full/overflow scenarios.
module tb_candidate_collector;

   logic        clk_fpga = 1'b0;
   logic        reset_fpga_n;
   logic        i_frame_start;
   logic        i_inspect_done;
   logic        i_candidate;
   logic [11:0] i_resize_x;
   logic [11:0] i_resize_y;
   logic        o_valid;
   logic        i_ready;
   logic [11:0] o_ori_x;
   logic [11:0] o_ori_y;
   logic [11:0] o_count;
   logic        o_overflow;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [23:0] exp_q [$];
   logic        prev_stall;
   logic [23:0] prev_data;

   always #5 clk_fpga = ~clk_fpga;

   candidate_collector #(
      .FIFO_DEPTH                   (4),
      .FRAME_ORIGINAL_CAMERA_WIDTH  (20),
      .FRAME_ORIGINAL_CAMERA_HEIGHT (20),
      .FRAME_RESIZE_CAMERA_WIDTH    (10),
      .FRAME_RESIZE_CAMERA_HEIGHT   (10),
      .MERGE_DIST                   (2)
   ) dut (
      .clk_fpga       (clk_fpga),
      .reset_fpga_n   (reset_fpga_n),
      .i_frame_start  (i_frame_start),
      .i_inspect_done (i_inspect_done),
      .i_candidate    (i_candidate),
      .i_resize_x     (i_resize_x),
      .i_resize_y     (i_resize_y),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_ori_x        (o_ori_x),
      .o_ori_y        (o_ori_y),
      .o_count        (o_count),
      .o_overflow     (o_overflow)
   );

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Present a hit for one edge; the expected result is queued if it should be written.
   task automatic hit_cycle(input logic [11:0] rx, input logic [11:0] ry,
                            input logic [11:0] ex, input logic [11:0] ey, input bit expect_push);
      i_inspect_done = 1'b1;
      i_candidate    = 1'b1;
      i_resize_x     = rx;
      i_resize_y     = ry;
      if (expect_push) exp_q.push_back({ex, ey});
      @(posedge clk_fpga); #1;
   endtask

   task automatic idle(input int n);
      i_inspect_done = 1'b0;
      i_candidate    = 1'b0;
      repeat (n) begin
         @(posedge clk_fpga); #1;
      end
   endtask

   task automatic frame_pulse();
      i_frame_start = 1'b1;
      @(posedge clk_fpga); #1;
      i_frame_start = 1'b0;
   endtask

   // Drain with a bounded cycle budget, then confirm that o_valid falls.
   task automatic drain(input string name);
      int budget;
      budget = 60;
      i_ready = 1'b1;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk_fpga); #1;
         budget--;
      end
      check({name, "_drained"}, 24'(exp_q.size()), 24'd0);
      idle(2);
      check({name, "_valid_low"}, {23'd0, o_valid}, 24'd0);
   endtask

   // Monitor: checks the scoreboard on every handshake and checks that the outputs hold during a stall.
   initial begin
      prev_stall = 1'b0;
      prev_data  = 24'd0;
      forever begin
         @(negedge clk_fpga);
         if (!reset_fpga_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", {23'd0, o_valid}, 24'd1);
               check("hold_data", {o_ori_x, o_ori_y}, prev_data);
            end
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: got (%0d,%0d), expected no result", o_ori_x, o_ori_y);
               end else begin
                  check("pop_data", {o_ori_x, o_ori_y}, exp_q.pop_front());
               end
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = {o_ori_x, o_ori_y};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_fpga_n   = 1'b0;
      i_frame_start  = 1'b0;
      i_inspect_done = 1'b0;
      i_candidate    = 1'b0;
      i_resize_x     = 12'd0;
      i_resize_y     = 12'd0;
      i_ready        = 1'b0;
      repeat (3) @(posedge clk_fpga);
      #1;
      check("rst_valid", {23'd0, o_valid}, 24'd0);
      check("rst_count", {12'd0, o_count}, 24'd0);
      check("rst_ovf", {23'd0, o_overflow}, 24'd0);
      check("rst_xy", {o_ori_x, o_ori_y}, 24'd0);
      reset_fpga_n = 1'b1;
      idle(2);

      // 1: single hit at (3,4) -> (6,8). o_valid rises at the third edge after the hit.
      i_ready = 1'b1;
      hit_cycle(12'd3, 12'd4, 12'd6, 12'd8, 1'b1);
      i_inspect_done = 1'b0;
      i_candidate    = 1'b0;
      check("t1_valid_e1", {23'd0, o_valid}, 24'd0);
      idle(1);
      check("t1_valid_e2", {23'd0, o_valid}, 24'd0);
      idle(1);
      check("t1_valid_e2b", {23'd0, o_valid}, 24'd0);
      check("t1_count", {12'd0, o_count}, 24'd1);
      idle(1);
      check("t1_valid_e3", {23'd0, o_valid}, 24'd1);
      check("t1_xy", {o_ori_x, o_ori_y}, {12'd6, 12'd8});
      idle(3);

      // 2: candidate without inspect_done is ignored.
      i_inspect_done = 1'b0;
      i_candidate    = 1'b1;
      i_resize_x     = 12'd7;
      i_resize_y     = 12'd7;
      repeat (4) begin
         @(posedge clk_fpga); #1;
      end
      idle(4);
      check("t2_valid", {23'd0, o_valid}, 24'd0);
      check("t2_count", {12'd0, o_count}, 24'd1);

      // Clamp and zero boundaries: (10,15) scales to (20,30), which clamps to (19,19).
      hit_cycle(12'd10, 12'd15, 12'd19, 12'd19, 1'b1);
      hit_cycle(12'd0, 12'd0, 12'd0, 12'd0, 1'b1);
      idle(6);
      check("clamp_count", {12'd0, o_count}, 24'd3);
      check("clamp_drained", 24'(exp_q.size()), 24'd0);

`ifdef CANDIDATE_MERGE_EN
      // 6: (3,3),(4,4),(8,8). The second result lies within 2 px of (6,6) and is merged.
      frame_pulse();
      i_ready = 1'b1;
      hit_cycle(12'd3, 12'd3, 12'd6, 12'd6, 1'b1);
      hit_cycle(12'd4, 12'd4, 12'd8, 12'd8, 1'b0);
      hit_cycle(12'd8, 12'd8, 12'd16, 12'd16, 1'b1);
      idle(8);
      check("t6_count", {12'd0, o_count}, 24'd2);
      check("t6_ovf", {23'd0, o_overflow}, 24'd0);
      drain("t6");
`else
      // 3: six back-to-back hits while stalled. Four are buffered and two are dropped.
      frame_pulse();
      check("t3_count_clr", {12'd0, o_count}, 24'd0);
      i_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         hit_cycle(12'd9, 12'd9, 12'd18, 12'd18, k < 4);
      end
      idle(6);
      check("t3_ovf", {23'd0, o_overflow}, 24'd1);
      check("t3_count", {12'd0, o_count}, 24'd4);
      check("t3_valid", {23'd0, o_valid}, 24'd1);
      check("t3_x", {12'd0, o_ori_x}, 24'd18);

      // 5: a frame start during the stall clears the counters but keeps the buffered results.
      frame_pulse();
      check("t5_count", {12'd0, o_count}, 24'd0);
      check("t5_ovf", {23'd0, o_overflow}, 24'd0);
      check("t5_valid", {23'd0, o_valid}, 24'd1);
      check("t5_y", {12'd0, o_ori_y}, 24'd18);

      // 4: the FIFO is full and a push coincides with a pop, so the push is accepted.
      hit_cycle(12'd5, 12'd7, 12'd10, 12'd14, 1'b1);
      idle(1);
      i_ready = 1'b1;
      idle(1);
      i_ready = 1'b0;
      idle(2);
      check("t4_ovf", {23'd0, o_overflow}, 24'd0);
      check("t4_count", {12'd0, o_count}, 24'd1);
      check("t4_valid", {23'd0, o_valid}, 24'd1);
      drain("t4");
`endif

      // Reset in mid-operation clears at once and discards in-flight and buffered results.
      i_ready = 1'b0;
      hit_cycle(12'd1, 12'd1, 12'd2, 12'd2, 1'b0);
      hit_cycle(12'd2, 12'd6, 12'd4, 12'd12, 1'b0);
      hit_cycle(12'd6, 12'd2, 12'd12, 12'd4, 1'b0);
      idle(1);
      reset_fpga_n = 1'b0;
      #2;
      check("mrst_valid", {23'd0, o_valid}, 24'd0);
      check("mrst_count", {12'd0, o_count}, 24'd0);
      exp_q.delete();
      idle(2);
      reset_fpga_n = 1'b1;
      i_ready = 1'b1;
      idle(6);
      check("mrst_valid_after", {23'd0, o_valid}, 24'd0);
      check("mrst_count_after", {12'd0, o_count}, 24'd0);
      check("final_queue", 24'(exp_q.size()), 24'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
